// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the bus arbiter: the arbiter state encoding and the
// width helpers used to size its internal counters.
// No ports (package).
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,  // CPU owns the bus, waiting for an instruction boundary
        PARK   = 2'd1,  // control ROM disabled, no grant yet (turnaround)
        GRANT  = 2'd2,  // external master owns the bus
        RESUME = 2'd3   // grant dropped, control ROM still disabled (turnaround)
    } arb_state_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Bits needed for a counter that must hold 0..max_value, never narrower
    // than one bit so a disabled feature (max_value = 0) still elaborates.
    function automatic int cnt_width(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder: returns the first eligible
// requester at or above rr_ptr, wrapping modulo N_REQ.
// Ports:
//   eligible  in  N_REQ  requesters allowed to win this cycle
//   rr_ptr    in  3      index with highest priority (must be < N_REQ)
//   winner    out 3      index of the selected requester (0 when none)
//   valid     out 1      at least one requester is eligible
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [2:0]       rr_ptr,
    output logic [2:0]       winner,
    output logic             valid
);

    logic [N_REQ-1:0] rotated;
    logic [3:0]       sum;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        // Bit j of rotated is requester (rr_ptr + j) mod N_REQ.
        rotated = N_REQ'({eligible, eligible} >> rr_ptr);
        // Walk from the lowest priority upward so the closest eligible
        // requester to rr_ptr is the last one written.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (|(rotated & (N_REQ'(1) << j))) begin
                sum = {1'b0, rr_ptr} + 4'(j);
                if (sum >= 4'(N_REQ)) begin
                    sum = sum - 4'(N_REQ);
                end
                winner = sum[2:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the CPU control-word/data bus between the microcoded control logic
// and N_REQ external masters. Ownership only changes at instruction
// boundaries (step_resetn low). Round-robin fairness between masters, a
// minimum number of CPU instructions between grants, and an optional hold
// timeout that locks a master out until it drops its request.
// Ports:
//   clk          in  1      system clock, rising edge
//   rst          in  1      synchronous reset, active-high
//   step_resetn  in  1      active-low instruction-boundary strobe
//   req          in  N_REQ  level requests, held for the whole transfer
//   ctrlen       out 1      active-low control ROM enable (0 = CPU owns bus)
//   gnt          out N_REQ  one-hot registered grant
//   owner        out 3      index of the current / last granted master
//   timeout      out 1      one-cycle pulse when a grant is revoked by HOLD_MAX
// -----------------------------------------------------------------------------
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int HOLD_MAX      = 255,
    parameter int CPU_MIN_INSTR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_resetn,
    input  logic [N_REQ-1:0] req,
    output logic             ctrlen,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       owner,
    output logic             timeout
);

    localparam int IW = cnt_width(CPU_MIN_INSTR);
    localparam int HW = cnt_width(HOLD_MAX);
    localparam logic [IW-1:0] INSTR_QUOTA = IW'(CPU_MIN_INSTR);
    localparam logic [HW-1:0] HOLD_LAST   = (HOLD_MAX == 0) ? '0 : HW'(HOLD_MAX - 1);
    localparam logic [2:0]    LAST_IDX    = 3'(N_REQ - 1);

    arb_state_t       state;
    logic [2:0]       rr_ptr;
    logic [2:0]       winner;
    logic [2:0]       pick;
    logic             pick_valid;
    logic [IW-1:0]    instr_cnt;
    logic [IW-1:0]    instr_next;
    logic [HW-1:0]    hold_cnt;
    logic [N_REQ-1:0] lockout;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] win_mask;
    logic             win_req;
    logic             quota_met;

    assign eligible = req & ~lockout;
    assign win_mask = N_REQ'(1) << winner;
    assign win_req  = |(req & win_mask);

    // The boundary being sampled already counts toward the quota.
    assign instr_next = (instr_cnt >= INSTR_QUOTA) ? instr_cnt : instr_cnt + IW'(1);
    assign quota_met  = (instr_next >= INSTR_QUOTA);

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (pick),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ctrlen    <= 1'b0;
            gnt       <= '0;
            owner     <= '0;
            timeout   <= 1'b0;
            rr_ptr    <= '0;
            winner    <= '0;
            instr_cnt <= INSTR_QUOTA;
            hold_cnt  <= '0;
            lockout   <= '0;
        end else begin
            // NOTE: non-blocking defaults at the top are overridden by any
            // later assignment in the same edge; the last one scheduled wins.
            timeout <= 1'b0;
            lockout <= lockout & req;

            case (state)
                RUN: begin
                    if (!step_resetn) begin
                        instr_cnt <= instr_next;
                        if (pick_valid && quota_met) begin
                            winner <= pick;
                            ctrlen <= 1'b1;
                            state  <= PARK;
                        end
                    end
                end

                PARK: begin
                    if (win_req) begin
                        gnt      <= win_mask;
                        owner    <= winner;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        state <= RESUME;
                    end
                end

                GRANT: begin
                    // Release is checked first so a master dropping req on
                    // the timeout edge is not penalised.
                    if (!win_req) begin
                        gnt   <= '0;
                        state <= RESUME;
                    end else if ((HOLD_MAX != 0) && (hold_cnt == HOLD_LAST)) begin
                        gnt     <= '0;
                        timeout <= 1'b1;
                        lockout <= (lockout | win_mask) & req;
                        state   <= RESUME;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                RESUME: begin
                    ctrlen    <= 1'b0;
                    instr_cnt <= '0;
                    rr_ptr    <= (winner == LAST_IDX) ? 3'd0 : winner + 3'd1;
                    state     <= RUN;
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Three arbiter instances with different parameters share one clock/reset:
//   dut 0: HOLD_MAX=255, CPU_MIN_INSTR=1  (basic latency, round robin, PARK
//          release, reset mid-grant)
//   dut 1: HOLD_MAX=255, CPU_MIN_INSTR=3  (instruction quota)
//   dut 2: HOLD_MAX=4,   CPU_MIN_INSTR=1  (timeout, lockout, release priority)
// Stimulus pushes the expected output snapshot and the cycle it must appear
// in; a negedge monitor pops an entry whenever a DUT's outputs change.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    typedef struct packed {
        logic       ctrlen;
        logic [1:0] gnt;
        logic [2:0] owner;
        logic       timeout;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sr  = 3'b111;
    logic [1:0] rq [3];
    logic [2:0] ce;
    logic [2:0] to;
    logic [1:0] gn [3];
    logic [2:0] ow [3];

    int    cyc      = 0;
    int    n_checks = 0;
    int    n_err    = 0;
    bit    mon_en   = 1'b0;
    exp_t  exp_q [3][$];
    snap_t last [3];
    logic [2:0] exp_owner [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_arbiter #(.N_REQ(2), .HOLD_MAX(255), .CPU_MIN_INSTR(1)) dut_a (
        .clk(clk), .rst(rst), .step_resetn(sr[0]), .req(rq[0]),
        .ctrlen(ce[0]), .gnt(gn[0]), .owner(ow[0]), .timeout(to[0])
    );

    bus_arbiter #(.N_REQ(2), .HOLD_MAX(255), .CPU_MIN_INSTR(3)) dut_b (
        .clk(clk), .rst(rst), .step_resetn(sr[1]), .req(rq[1]),
        .ctrlen(ce[1]), .gnt(gn[1]), .owner(ow[1]), .timeout(to[1])
    );

    bus_arbiter #(.N_REQ(2), .HOLD_MAX(4), .CPU_MIN_INSTR(1)) dut_c (
        .clk(clk), .rst(rst), .step_resetn(sr[2]), .req(rq[2]),
        .ctrlen(ce[2]), .gnt(gn[2]), .owner(ow[2]), .timeout(to[2])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // Monitor: invariant every cycle, scoreboard pop on every output change.
    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                cur = {ce[d], gn[d], ow[d], to[d]};
                if (cur.gnt != 2'b00) begin
                    check($sformatf("invariant_ctrlen_with_gnt dut%0d", d), 64'(cur.ctrlen), 64'(1));
                end
                if (cur != last[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_change dut%0d at cyc %0d: got %b, expected unchanged %b",
                                 d, cyc, cur, last[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        check($sformatf("event_value dut%0d", d), 64'(cur), 64'(e.s));
                        check($sformatf("event_cycle dut%0d", d), 64'(cyc), 64'(e.cyc));
                    end
                    last[d] = cur;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int d, input int at, input logic c, input logic [1:0] g,
                              input logic [2:0] o, input logic t);
        exp_t e;
        e.s   = {c, g, o, t};
        e.cyc = at;
        exp_q[d].push_back(e);
    endtask

    // step_resetn low for exactly one sampling edge; returns just after it.
    task automatic boundary(input int d);
        sr[d] = 1'b0;
        tick(1);
        sr[d] = 1'b1;
    endtask

    // Boundary -> grant to idx -> stray boundary inside GRANT (ignored) ->
    // hold extra cycles -> master idx releases (optionally re-requests).
    task automatic grant_cycle(input int d, input int idx, input int hold, input bit reraise);
        int t;
        int u;
        logic [1:0] m;
        m = 2'b01 << idx;
        t = cyc + 1;
        expect_evt(d, t,     1'b1, 2'b00, exp_owner[d], 1'b0);
        expect_evt(d, t + 1, 1'b1, m,     3'(idx),      1'b0);
        exp_owner[d] = 3'(idx);
        boundary(d);
        tick(1);
        boundary(d);
        tick(hold);
        u = cyc + 1;
        expect_evt(d, u,     1'b1, 2'b00, 3'(idx), 1'b0);
        expect_evt(d, u + 1, 1'b0, 2'b00, 3'(idx), 1'b0);
        rq[d] = rq[d] & ~m;
        tick(1);
        if (reraise) rq[d] = rq[d] | m;
        tick(2);
    endtask

    initial begin
        int t;
        for (int d = 0; d < 3; d++) begin
            rq[d]        = 2'b00;
            exp_owner[d] = 3'd0;
            last[d]      = '0;
        end
        tick(3);
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state of every instance.
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ctrlen dut%0d", d),  64'(ce[d]), 64'(0));
            check($sformatf("reset_gnt dut%0d", d),     64'(gn[d]), 64'(0));
            check($sformatf("reset_owner dut%0d", d),   64'(ow[d]), 64'(0));
            check($sformatf("reset_timeout dut%0d", d), 64'(to[d]), 64'(0));
        end

        // dut 0: request with no boundary for 10 cycles -> nothing happens,
        // then boundary grants master 0; rr_ptr moves to 1.
        rq[0] = 2'b01;
        tick(10);
        grant_cycle(0, 0, 3, 1'b0);

        // dut 0: both requesting, grants alternate 10, 01, 10.
        rq[0] = 2'b11;
        tick(1);
        grant_cycle(0, 1, 3, 1'b1);
        grant_cycle(0, 0, 3, 1'b1);
        grant_cycle(0, 1, 3, 1'b1);

        // dut 0: request dropped while parked -> no grant, ctrlen back 2 later.
        rq[0] = 2'b01;
        tick(1);
        t = cyc + 1;
        expect_evt(0, t,     1'b1, 2'b00, exp_owner[0], 1'b0);
        expect_evt(0, t + 2, 1'b0, 2'b00, exp_owner[0], 1'b0);
        boundary(0);
        rq[0] = 2'b00;
        tick(4);

        // dut 1: quota pre-satisfied after reset, then 3 boundaries needed.
        rq[1] = 2'b01;
        tick(1);
        grant_cycle(1, 0, 2, 1'b1);
        boundary(1);
        tick(2);
        boundary(1);
        tick(2);
        grant_cycle(1, 0, 2, 1'b0);

        // dut 2: held request -> 4 grant cycles, timeout pulse, lockout.
        rq[2] = 2'b01;
        tick(1);
        t = cyc + 1;
        expect_evt(2, t,     1'b1, 2'b00, 3'd0, 1'b0);
        expect_evt(2, t + 1, 1'b1, 2'b01, 3'd0, 1'b0);
        expect_evt(2, t + 5, 1'b1, 2'b00, 3'd0, 1'b1);
        expect_evt(2, t + 6, 1'b0, 2'b00, 3'd0, 1'b0);
        boundary(2);
        tick(8);
        boundary(2);        // master 0 still locked out: ignored
        tick(3);
        rq[2] = 2'b00;      // drop clears the lockout
        tick(1);
        rq[2] = 2'b01;
        tick(1);
        // Release lands on the exact timeout edge: release wins, no pulse.
        grant_cycle(2, 0, 2, 1'b1);
        grant_cycle(2, 0, 1, 1'b0);

        // dut 0: synchronous reset in the middle of a grant.
        rq[0] = 2'b01;
        tick(1);
        t = cyc + 1;
        expect_evt(0, t,     1'b1, 2'b00, exp_owner[0], 1'b0);
        expect_evt(0, t + 1, 1'b1, 2'b01, 3'd0,         1'b0);
        boundary(0);
        tick(2);
        rst = 1'b1;
        expect_evt(0, cyc + 1, 1'b0, 2'b00, 3'd0, 1'b0);
        tick(1);
        rst = 1'b0;
        rq[0] = 2'b00;
        tick(4);

        for (int d = 0; d < 3; d++) begin
            check($sformatf("pending_events dut%0d", d), 64'(exp_q[d].size()), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
